// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, byte-enabled writes, fixed LAT-cycle response.
// Outputs are registered from next-state; writes commit on the accept edge, reads are captured there.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [31:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic accept, is_read, we_legal;
  logic err_q, err_nxt, rd_q, rd_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic addr_unused;

  assign idx = req_addr[DEPTH_LOG2+1:2];
  assign addr_unused = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  // rst wins over a simultaneous request: no accept, no array write.
  assign accept = (state == IDLE) && req_en && !rst;
  assign is_read = (req_we == 4'b0000);

  always_comb begin
    we_legal = 1'b0;
    case (req_we)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: we_legal = 1'b1;
      default:                   we_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    rd_nxt    = rd_q;
    hold_nxt  = hold_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          err_nxt = !is_read && !we_legal;
          rd_nxt  = is_read;
          if (is_read) hold_nxt = mem[idx];
          if (LAT > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      hold_q     <= 32'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      err_q      <= err_nxt;
      rd_q       <= rd_nxt;
      hold_q     <= hold_nxt;
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= (state_nxt == RESP);
      resp_err   <= (state_nxt == RESP) && err_nxt;
      // Only read responses move resp_rdata, so it holds across write responses.
      if (state_nxt == RESP && rd_nxt) resp_rdata <= hold_nxt;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && !is_read && we_legal) begin
      for (int i = 0; i < 4; i++) begin
        if (req_we[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LAT=0, LAT=3 and LAT=5 sharing clk/rst.
module tb_dmem_responder;
  logic clk;
  logic rst;
  logic [2:0]       req_en;
  logic [2:0][3:0]  req_we;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0]       req_ready;
  logic [2:0]       resp_valid;
  logic [2:0][31:0] resp_rdata;
  logic [2:0]       resp_err;

  int n_checks = 0;
  int n_fail = 0;

  dmem_responder #(.DEPTH_LOG2(10), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .req_en(req_en[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_responder #(.DEPTH_LOG2(10), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_en(req_en[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  dmem_responder #(.DEPTH_LOG2(10), .LAT(5)) u_lat5 (
    .clk(clk), .rst(rst), .req_en(req_en[2]), .req_we(req_we[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .req_ready(req_ready[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance k; checks ready/valid every cycle up to the first idle cycle.
  task automatic run(input int k, input int lat, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    @(negedge clk);
    chk({tag, " ready_before"}, 32'(req_ready[k]), 32'd1);
    req_en[k] = 1'b1;
    req_we[k] = we;
    req_addr[k] = addr;
    req_wdata[k] = wd;
    @(negedge clk);
    req_en[k] = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      chk($sformatf("%s ready_c%0d", tag, c), 32'(req_ready[k]), 32'd0);
      chk($sformatf("%s valid_c%0d", tag, c), 32'(resp_valid[k]), 32'(c == lat + 1));
      if (c == lat + 1) begin
        chk({tag, " rdata"}, resp_rdata[k], exp_rd);
        chk({tag, " err"}, 32'(resp_err[k]), 32'(exp_err));
      end else begin
        chk($sformatf("%s err_c%0d", tag, c), 32'(resp_err[k]), 32'd0);
      end
      @(negedge clk);
    end
    chk({tag, " ready_after"}, 32'(req_ready[k]), 32'd1);
    chk({tag, " valid_after"}, 32'(resp_valid[k]), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];
  int nv;

  initial begin
    rst = 1'b1;
    req_en = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;

    // LAT=0 sequence; writes expect resp_rdata to hold the previous read value.
    vecs[0]  = '{4'b1111, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{4'b0000, 32'h0000_0100, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{4'b0010, 32'h0000_0100, 32'hAAAA_AAAA, 32'h1234_5678, 1'b0};
    vecs[3]  = '{4'b0000, 32'h0000_0100, 32'h0,         32'h1234_AA78, 1'b0};
    vecs[4]  = '{4'b1100, 32'h0000_0102, 32'hBEEF_BEEF, 32'h1234_AA78, 1'b0};
    vecs[5]  = '{4'b0000, 32'h0000_0101, 32'h0,         32'hBEEF_AA78, 1'b0};
    vecs[6]  = '{4'b1111, 32'h0000_0200, 32'h0000_0000, 32'hBEEF_AA78, 1'b0};
    vecs[7]  = '{4'b0101, 32'h0000_0200, 32'hFFFF_FFFF, 32'hBEEF_AA78, 1'b1};
    vecs[8]  = '{4'b0000, 32'h0000_0200, 32'h0,         32'h0000_0000, 1'b0};
    vecs[9]  = '{4'b1111, 32'h0000_0008, 32'h1111_1111, 32'h0000_0000, 1'b0};
    vecs[10] = '{4'b0000, 32'h0000_1008, 32'h0,         32'h1111_1111, 1'b0};
    vecs[11] = '{4'b0110, 32'h0000_0008, 32'h2222_2222, 32'h1111_1111, 1'b1};
    vecs[12] = '{4'b1000, 32'hFFFF_F00B, 32'h3333_3333, 32'h1111_1111, 1'b0};
    vecs[13] = '{4'b0000, 32'h0000_0008, 32'h0,         32'h3311_1111, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d ready", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("reset%0d valid", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("reset%0d err", k), 32'(resp_err[k]), 32'd0);
      chk($sformatf("reset%0d rdata", k), resp_rdata[k], 32'd0);
    end

    for (int i = 0; i < 14; i++)
      run(0, 0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err,
          $sformatf("vec%0d", i));

    // rst coincident with a request: not accepted, array untouched.
    @(negedge clk);
    rst = 1'b1;
    req_en[0] = 1'b1;
    req_we[0] = 4'b1111;
    req_addr[0] = 32'h0000_0100;
    req_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    req_en[0] = 1'b0;
    chk("rst_vs_req ready", 32'(req_ready[0]), 32'd1);
    chk("rst_vs_req valid", 32'(resp_valid[0]), 32'd0);
    run(0, 0, 4'b0000, 32'h0000_0100, 32'h0, 32'hBEEF_AA78, 1'b0, "rst_vs_req read");

    // LAT=3 latency and back-to-back acceptance.
    run(1, 3, 4'b1111, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0, 1'b0, "lat3 wr");
    run(1, 3, 4'b0000, 32'h0000_0010, 32'h0, 32'hA5A5_A5A5, 1'b0, "lat3 rd");
    @(negedge clk);
    chk("b2b ready_before", 32'(req_ready[1]), 32'd1);
    req_en[1] = 1'b1;
    req_we[1] = 4'b1111;
    req_addr[1] = 32'h0000_0014;
    req_wdata[1] = 32'h5A5A_5A5A;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("b2b ready_c%0d", c), 32'(req_ready[1]), 32'((c == 5) || (c >= 10)));
      chk($sformatf("b2b valid_c%0d", c), 32'(resp_valid[1]), 32'((c == 4) || (c == 9)));
      if (c == 4) chk("b2b wr rdata_held", resp_rdata[1], 32'hA5A5_A5A5);
      if (c == 9) chk("b2b rd rdata", resp_rdata[1], 32'h5A5A_5A5A);
      if (c == 1) begin
        req_we[1] = 4'b0000;
        req_addr[1] = 32'h0000_0014;
      end
      if (c == 6) req_en[1] = 1'b0;
    end

    // LAT=5: reset during WAIT aborts the response but keeps the committed write.
    @(negedge clk);
    chk("abort ready_before", 32'(req_ready[2]), 32'd1);
    req_en[2] = 1'b1;
    req_we[2] = 4'b1111;
    req_addr[2] = 32'h0000_0040;
    req_wdata[2] = 32'hCAFE_F00D;
    @(negedge clk);
    req_en[2] = 1'b0;
    chk("abort ready_t1", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort ready_after_rst", 32'(req_ready[2]), 32'd1);
    chk("abort valid_after_rst", 32'(resp_valid[2]), 32'd0);
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid[2]) nv++;
      @(negedge clk);
    end
    chk("abort no_valid", 32'(nv), 32'd0);
    run(2, 5, 4'b0000, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b0, "abort read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
